// File: rtl/seg7_pkg.sv
// Shared types for the seven-segment scan path: BCD digit type and scan FSM states.
package seg7_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero suppression mask: bit i set when digit i and all more-significant
// digits are zero and digit i carries no decimal point. Digit 0 is always shown.
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [BCD_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]       dp,
  output logic [NUM_DIGITS-1:0]       suppress
);

  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    suppress   = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero && (value[BCD_W*i +: BCD_W] == '0);
      suppress[i] = upper_zero && !dp[i];
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment display with a blanking
// gap per digit slot and tear-free (frame-boundary) commit of new display values.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 250,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        blank_zeros,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]       load_dp,
  output bcd_t                        seg_digit,
  output logic                        seg_dp,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] slot_cnt, slot_cnt_nxt;
  logic             enter_blank, enter_show;

  logic [BCD_W*NUM_DIGITS-1:0] act_val, act_val_nxt, pend_val;
  logic [NUM_DIGITS-1:0]       act_dp, act_dp_nxt, pend_dp;
  logic                        pend_full, pend_full_nxt, pend_load;
  logic                        handshake;

  logic                  bz_slot;
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] idx_onehot;
  bcd_t                  next_digit;
  logic                  next_dp;

  seg7_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .value   (act_val),
    .dp      (act_dp),
    .suppress(suppress)
  );

  // Scan sequencing: IDLE -> BLANK -> SHOW -> BLANK (next digit) ...
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    slot_cnt_nxt = slot_cnt + 1'b1;
    enter_blank  = 1'b0;
    enter_show   = 1'b0;
    if (!enable) begin
      state_nxt    = IDLE;
      idx_nxt      = '0;
      slot_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt    = BLANK;
          idx_nxt      = '0;
          slot_cnt_nxt = '0;
          enter_blank  = 1'b1;
        end
        BLANK: begin
          if (slot_cnt == BLANK_LAST) begin
            state_nxt  = SHOW;
            enter_show = 1'b1;
          end
        end
        SHOW: begin
          if (slot_cnt == SLOT_LAST) begin
            state_nxt    = BLANK;
            slot_cnt_nxt = '0;
            idx_nxt      = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            enter_blank  = 1'b1;
          end
        end
        default: begin
          state_nxt    = IDLE;
          idx_nxt      = '0;
          slot_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign frame_done = (state == SHOW) && (idx == IDX_LAST) && (slot_cnt == SLOT_LAST);
  assign load_ready = !pend_full;
  assign handshake  = load_valid && load_ready;
  assign idx_onehot = NUM_DIGITS'(1) << idx;

  // Value buffering. While dark there is nothing to tear, so a stranded pending
  // value is flushed straight to active rather than waiting for a boundary.
  always_comb begin
    act_val_nxt   = act_val;
    act_dp_nxt    = act_dp;
    pend_full_nxt = pend_full;
    pend_load     = 1'b0;
    if (state == IDLE || frame_done) begin
      if (handshake) begin
        act_val_nxt = load_value;
        act_dp_nxt  = load_dp;
      end else if (pend_full) begin
        act_val_nxt   = pend_val;
        act_dp_nxt    = pend_dp;
        pend_full_nxt = 1'b0;
      end
    end else if (handshake) begin
      pend_load     = 1'b1;
      pend_full_nxt = 1'b1;
    end
  end

  // The boundary commit lands on the same edge that enters BLANK for digit 0,
  // so the digit fetched for the new slot must come from the post-commit value.
  always_comb begin
    next_digit = act_val_nxt[BCD_W*int'(idx_nxt) +: BCD_W];
    next_dp    = act_dp_nxt[idx_nxt];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      slot_cnt  <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      pend_full <= 1'b0;
      bz_slot   <= 1'b0;
      seg_digit <= '0;
      seg_dp    <= 1'b0;
      digit_en  <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      slot_cnt  <= slot_cnt_nxt;
      act_val   <= act_val_nxt;
      act_dp    <= act_dp_nxt;
      pend_full <= pend_full_nxt;
      if (enter_blank) begin
        seg_digit <= next_digit;
        seg_dp    <= next_dp;
        bz_slot   <= blank_zeros;
        digit_en  <= '0;
      end else if (enter_show) begin
        digit_en <= (bz_slot && suppress[idx]) ? '0 : idx_onehot;
      end else if (!enable) begin
        digit_en <= '0;
      end
    end
  end

  // Pending buffer is data only; its occupancy flag carries validity.
  always_ff @(posedge clk) begin
    if (pend_load) begin
      pend_val <= load_value;
      pend_dp  <= load_dp;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed + randomized bench for seg7_scan_ctrl against a cycle-count based reference model.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int S = 10;
  localparam int B = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        blank_zeros;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_dp;
  logic [3:0]  seg_digit;
  logic        seg_dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int fd_cnt;

  // Reference model: a running flag plus a cycle index within the frame.
  bit          m_run;
  int          m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pfull;
  bit          m_bz;
  logic [3:0]  m_seg;
  logic        m_sdp;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (S),
    .BLANK_CYCLES(B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .blank_zeros(blank_zeros),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dp    (load_dp),
    .seg_digit  (seg_digit),
    .seg_dp     (seg_dp),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] dig(input logic [15:0] v, input int i);
    return v[4*i +: 4];
  endfunction

  function automatic bit supp(input logic [15:0] v, input logic [3:0] d, input int i);
    if (i == 0) return 1'b0;
    if (d[i]) return 1'b0;
    for (int j = i; j < N; j++)
      if (dig(v, j) != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit bnd;
    bit hs;
    if (reset) begin
      m_run = 0; m_t = 0; m_act = '0; m_dp = '0; m_pfull = 0;
      m_bz = 0; m_seg = '0; m_sdp = 1'b0;
      return;
    end
    bnd = m_run && (m_t == S*N - 1);
    hs  = load_valid && !m_pfull;
    if (!m_run || bnd) begin
      if (hs) begin
        m_act = load_value; m_dp = load_dp;
      end else if (m_pfull) begin
        m_act = m_pend; m_dp = m_pdp; m_pfull = 0;
      end
    end else if (hs) begin
      m_pend = load_value; m_pdp = load_dp; m_pfull = 1;
    end
    if (!enable) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else begin
      m_t = (m_t + 1) % (S*N);
    end
    if (m_run && (m_t % S == 0)) begin
      m_bz  = blank_zeros;
      m_seg = dig(m_act, m_t / S);
      m_sdp = m_dp[m_t / S];
    end
  endtask

  task automatic check_outputs();
    int pos;
    int idx;
    logic [3:0] een;
    pos = m_t % S;
    idx = m_t / S;
    een = '0;
    if (m_run && pos >= B && !(m_bz && supp(m_act, m_dp, idx)))
      een = 4'b0001 << idx;
    chk("digit_en",   32'(digit_en),   32'(een));
    chk("seg_digit",  32'(seg_digit),  32'(m_seg));
    chk("seg_dp",     32'(seg_dp),     32'(m_sdp));
    chk("frame_done", 32'(frame_done), 32'(m_run && pos == S-1 && idx == N-1));
    chk("load_ready", 32'(load_ready), 32'(!m_pfull));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run_until_t(input int target, input string tag);
    for (int k = 0; k < 200; k++) begin
      if (m_run && m_t == target) break;
      step();
    end
    chk(tag, 32'(m_run && m_t == target), 32'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; blank_zeros = 1'b0;
    load_valid = 1'b0; load_value = '0; load_dp = '0;
    m_pend = '0; m_pdp = '0;

    // Reset with enable held, then free-running scan of an all-zero value.
    step(); step();
    reset = 1'b0;
    fd_cnt = 0;
    repeat (80) begin
      step();
      if (frame_done) fd_cnt++;
    end
    chk("frame_done_per_80", 32'(fd_cnt), 32'd2);

    // Load while dark commits immediately.
    enable = 1'b0;
    step(); step();
    load_valid = 1'b1; load_value = 16'h1234; load_dp = 4'b0000;
    step();
    load_valid = 1'b0;
    enable = 1'b1;
    repeat (45) step();

    // Mid-frame load with leading-zero suppression; second offer held off.
    blank_zeros = 1'b1;
    run_until_t(15, "reach_mid_frame");
    load_valid = 1'b1; load_value = 16'h0007; load_dp = 4'b0000;
    step();
    load_value = 16'h0042;
    repeat (5) step();
    load_valid = 1'b0;
    run_until_t(39, "reach_boundary_1");
    repeat (45) step();

    // Handshake exactly on the boundary cycle bypasses pending.
    run_until_t(39, "reach_boundary_2");
    load_valid = 1'b1; load_value = 16'h0900; load_dp = 4'b0010;
    step();
    load_valid = 1'b0;
    repeat (42) step();

    // Drop enable during SHOW of digit 2, then restart.
    run_until_t(25, "reach_show_idx2");
    enable = 1'b0;
    step(); step();
    enable = 1'b1;
    repeat (15) step();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 49) == 0) blank_zeros = ~blank_zeros;
      load_valid = ($urandom_range(0, 19) == 0);
      for (int d = 0; d < N; d++)
        load_value[4*d +: 4] = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      load_dp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      step();
    end
    enable = 1'b1; load_valid = 1'b0;

    // Reset mid-SHOW with the pending buffer full.
    run_until_t(5, "reach_slot0_show");
    load_valid = 1'b1; load_value = 16'h5678; load_dp = 4'b1000;
    step();
    load_valid = 1'b0;
    run_until_t(13, "reach_slot1_show");
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (45) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
